// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle control unit and the mini-cpu datapath.
// Carries instruction fields, ALU zero flag and memory handshake into the controller,
// and the datapath mux selects, ALU op, memory request and status flags out of it.
interface multicycle_ctrl_if;
    // Datapath -> controller
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    // Controller -> datapath
    logic       mem_req;
    logic       mem_we;
    logic       addr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic       retire;
    logic       illegal;

    // The controller is the driving end of the control bundle.
    modport master (
        input  opcode, funct3, funct7b5, zero, mem_ready,
        output mem_req, mem_we, addr_src, ir_write, pc_write, reg_write,
               result_src, alu_src_a, alu_src_b, alu_ctrl, retire, illegal
    );

    modport slave (
        output opcode, funct3, funct7b5, zero, mem_ready,
        input  mem_req, mem_we, addr_src, ir_write, pc_write, reg_write,
               result_src, alu_src_a, alu_src_b, alu_ctrl, retire, illegal
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I-subset control FSM: fetch/decode/execute/memory/writeback sequencing.
// Latency: 3-5 cycles per instruction plus one per memory wait cycle; outputs combinational from state.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold with stable request until mem_ready=1.
// Ports: clk, rst_n (async active-low), bus (multicycle_ctrl_if.master: instruction fields,
//        zero, mem_ready in; mem/mux/ALU controls, retire, illegal out).
module multicycle_ctrl (
    input  logic                clk,
    input  logic                rst_n,
    multicycle_ctrl_if.master   bus
);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALUWB, S_MEMADR,
        S_MEMREAD, S_MEMWB, S_MEMWRITE, S_BEQ, S_JAL, S_TRAP
    } state_e;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_e state_q, state_d;

    logic       mem_req, mem_we, addr_src, ir_write, pc_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [2:0] alu_ctrl;
    logic       retire, illegal;

    // ALU op for the execute states; exec_ok low means funct3 is not supported.
    logic       exec_ok;
    logic [2:0] exec_op;

    always_comb begin
        exec_ok = 1'b1;
        exec_op = ALU_ADD;
        case (bus.funct3)
            3'b000: exec_op = (state_q == S_EXEC_R && bus.funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010: exec_op = ALU_SLT;
            3'b110: exec_op = ALU_OR;
            3'b111: exec_op = ALU_AND;
            default: exec_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_src   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_ctrl   = ALU_AND;
        retire     = 1'b0;
        illegal    = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_FETCH;

            // PC + 4 is computed while the instruction is read; both land on completion.
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                alu_ctrl   = ALU_ADD;
                result_src = 2'b10;
                if (bus.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end

            // Old PC + immediate is precomputed into ALUOut as the branch target.
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                alu_ctrl  = ALU_ADD;
                case (bus.opcode)
                    OP_R:          state_d = S_EXEC_R;
                    OP_I:          state_d = S_EXEC_I;
                    OP_LW, OP_SW:  state_d = (bus.funct3 == 3'b010) ? S_MEMADR : S_TRAP;
                    OP_BEQ:        state_d = (bus.funct3 == 3'b000) ? S_BEQ : S_TRAP;
                    OP_JAL:        state_d = S_JAL;
                    default:       state_d = S_TRAP;
                endcase
            end

            // An unsupported funct3 already presents the trap outputs in this cycle.
            S_EXEC_R, S_EXEC_I: begin
                if (exec_ok) begin
                    alu_src_a = 2'b10;
                    alu_src_b = (state_q == S_EXEC_I) ? 2'b01 : 2'b00;
                    alu_ctrl  = exec_op;
                    state_d   = S_ALUWB;
                end else begin
                    illegal = 1'b1;
                    state_d = S_TRAP;
                end
            end

            S_ALUWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end

            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_ctrl  = ALU_ADD;
                if (bus.opcode == OP_LW) begin
                    state_d = S_MEMREAD;
                end else if (bus.opcode == OP_SW) begin
                    state_d = S_MEMWRITE;
                end else begin
                    state_d = S_TRAP;
                end
            end

            S_MEMREAD: begin
                mem_req  = 1'b1;
                addr_src = 1'b1;
                if (bus.mem_ready) begin
                    state_d = S_MEMWB;
                end
            end

            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end

            S_MEMWRITE: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                addr_src = 1'b1;
                if (bus.mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end

            // Taken branch loads the target held in ALUOut since DECODE.
            S_BEQ: begin
                alu_src_a = 2'b10;
                alu_ctrl  = ALU_SUB;
                pc_write  = bus.zero;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end

            // PC <- target from ALUOut while the ALU forms old PC + 4 for the link.
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                alu_ctrl  = ALU_ADD;
                pc_write  = 1'b1;
                state_d   = S_ALUWB;
            end

            S_TRAP: begin
                illegal = 1'b1;
            end

            default: state_d = S_TRAP;
        endcase
    end

    assign bus.mem_req    = mem_req;
    assign bus.mem_we     = mem_we;
    assign bus.addr_src   = addr_src;
    assign bus.ir_write   = ir_write;
    assign bus.pc_write   = pc_write;
    assign bus.reg_write  = reg_write;
    assign bus.result_src = result_src;
    assign bus.alu_src_a  = alu_src_a;
    assign bus.alu_src_b  = alu_src_b;
    assign bus.alu_ctrl   = alu_ctrl;
    assign bus.retire     = retire;
    assign bus.illegal    = illegal;

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control unit for the mini-cpu datapath. It is the driving end of the ALU control interface: it issues `alu_ctrl` and the datapath mux selects, and it consumes the ALU `zero` flag and a memory ready handshake. A Moore-style FSM with Mealy handshake terms steps each RV32I-subset instruction through fetch, decode, execute, memory and writeback. Supported instructions: add, sub, and, or, slt, addi, andi, ori, slti, lw, sw, beq, jal.

## Interface
Parameters:
- none. Control widths are fixed by the datapath.

Ports:
- `clk` input 1: the single clock. All state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `opcode` input 7: instruction register bits [6:0].
- `funct3` input 3: instruction register bits [14:12].
- `funct7b5` input 1: instruction register bit 30.
- `zero` input 1: ALU zero flag.
- `mem_ready` input 1: memory completed the current request.
- `mem_req` output 1: memory request.
- `mem_we` output 1: write when 1, read when 0.
- `addr_src` output 1: memory address source. 0 = PC, 1 = ALUOut.
- `ir_write` output 1: load the instruction register and the old-PC register.
- `pc_write` output 1: load PC from the result bus.
- `reg_write` output 1: register file write to rd.
- `result_src` output 2: result bus source. 00 = ALUOut, 01 = memory data, 10 = ALU result.
- `alu_src_a` output 2: ALU A source. 00 = PC, 01 = old PC, 10 = register A.
- `alu_src_b` output 2: ALU B source. 00 = register B, 01 = immediate, 10 = constant 4.
- `alu_ctrl` output 3: ALU operation. 000 = AND, 001 = OR, 010 = ADD, 110 = SUB, 111 = SLT.
- `retire` output 1: one-cycle pulse in the final cycle of each instruction.
- `illegal` output 1: sticky flag for an unsupported instruction.

## Operation
Output rule:
- Any output not listed for the current state is 0.

States and their outputs:
- IDLE: entered on reset. All outputs 0. Moves to FETCH on the next edge.
- FETCH: mem_req=1, addr_src=0, alu_src_a=00, alu_src_b=10, alu_ctrl=ADD, result_src=10.
  - If mem_ready=1: ir_write=1 and pc_write=1 in the same cycle, then go to DECODE.
  - If mem_ready=0: stay in FETCH.
- DECODE: alu_src_a=01, alu_src_b=01, ADD (branch target into ALUOut). Next state by opcode:
  - 0110011 → EXEC_R.
  - 0010011 → EXEC_I.
  - 0000011 or 0100011 → MEMADR, only when funct3=010.
  - 1100011 → BEQ, only when funct3=000.
  - 1101111 → JAL.
  - Anything else → TRAP.
- EXEC_R and EXEC_I: alu_src_a=10; alu_src_b is 00 for EXEC_R, 01 for EXEC_I. alu_ctrl decodes funct3:
  - 000 → ADD. EXEC_R with funct7b5=1 gives SUB instead; EXEC_I ignores funct7b5.
  - 010 → SLT.
  - 110 → OR.
  - 111 → AND.
  - Any other funct3 → TRAP, with outputs as in TRAP. Otherwise go to ALUWB.
- ALUWB: result_src=00, reg_write=1, retire=1. Go to FETCH.
- MEMADR: alu_src_a=10, alu_src_b=01, ADD. Go to MEMREAD for opcode 0000011, MEMWRITE for 0100011.
- MEMREAD: mem_req=1, addr_src=1. Hold until mem_ready=1, then go to MEMWB.
- MEMWB: result_src=01, reg_write=1, retire=1. Go to FETCH.
- MEMWRITE: mem_req=1, mem_we=1, addr_src=1. Hold until mem_ready=1; in that cycle retire=1. Go to FETCH.
- BEQ: alu_src_a=10, alu_src_b=00, SUB, result_src=00, pc_write=zero, retire=1. Go to FETCH.
- JAL: alu_src_a=01, alu_src_b=10, ADD, result_src=00, pc_write=1. Go to ALUWB, which writes old PC + 4 to rd.
- TRAP: illegal=1, all other outputs 0. Stays in TRAP until reset.

Outputs are combinational from state. The only input-dependent terms are `mem_ready`, `zero` and the funct fields.

## Timing
Reset:
- rst_n low forces IDLE immediately, asynchronously, including mid-instruction or mid-memory-wait. Every output reads 0, including illegal.
- The first FETCH is one cycle after rst_n deasserts.

Cycles per instruction, with mem_ready=1 on the first request cycle:
- R-type and I-type: 4.
- lw: 5.
- sw: 4.
- beq: 3.
- jal: 4.
- Each memory wait cycle adds 1.

Handshake rules:
- mem_req, mem_we and addr_src stay stable until the cycle where mem_ready=1. The request completes in that cycle.
- mem_ready is ignored in all non-request states.
- No back-to-back request without a state change.

Other rules:
- retire is high exactly once per completed instruction. It is never high in TRAP.
- zero is sampled only in BEQ.

## Test plan
- Reset then add (opcode 0110011, funct3 000, funct7b5 0), mem_ready tied 1:
  - States IDLE → FETCH → DECODE → EXEC_R → ALUWB.
  - alu_ctrl=010 in EXEC_R; reg_write=1 and retire=1 in ALUWB.
  - Repeat with funct7b5=1 → alu_ctrl=110.
- lw with mem_ready held 0 for 3 cycles in both FETCH and MEMREAD:
  - mem_req and addr_src stay stable across the waits.
  - Total 11 cycles; MEMWB has result_src=01, reg_write=1.
- beq with zero=1 → pc_write=1 in BEQ, alu_ctrl=110, 3 cycles. With zero=0 → pc_write=0, retire still 1.
- jal:
  - JAL state has pc_write=1, result_src=00.
  - Next cycle ALUWB has reg_write=1.
  - retire appears once over the 4 cycles.
- Illegal cases → TRAP, illegal=1 held for 20 cycles; then rst_n low → illegal=0 immediately. Triggers:
  - opcode 1110011.
  - R-type with funct3=001.
  - lw with funct3=000.
- rst_n pulsed low mid-MEMWRITE wait → outputs 0 asynchronously; after release, FETCH one cycle later.
